tile_scheduler: RTL
===================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ROWS, 4, PE rows.
- COLS, 4, PE columns.
- MAX_N, 64, max matrix dimension.
- N_BITS, $clog2(MAX_N), coordinate width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset (asserted when 0).
- stall  in  1  freeze all sequencing.
- start  in  1  begin layer; sampled only in IDLE.
- mat_rows  in  N_BITS+1  output rows, legal 1..MAX_N.
- mat_cols  in  N_BITS+1  output cols, legal 1..MAX_N.
- tile_done  in  1  array finished accumulating current tile.
- sta_idle  in  1  systolic array idle.
- oc_idle  in  1  output coordinator idle.
- busy  out  1  high in any state except IDLE.
- tile_start  out  1  one-cycle pulse launching current tile.
- pos_row  out  N_BITS  current tile base row.
- pos_col  out  N_BITS  current tile base col.
- pe_mask  out  1 x [ROWS*COLS]  per-PE active flag.
- oc_done  out  1  drives output coordinator done.
- layer_done  out  1  one-cycle pulse, all tiles emitted.
- cfg_err  out  1  one-cycle pulse, illegal start dims.

Function
REQ-004 States: IDLE, ISSUE, COMPUTE, DRAIN, FLUSH, NEXT, FIN.
REQ-005 IDLE: on start, latch mat_rows/mat_cols, clear pos_row/pos_col to 0.
- dims in 1..MAX_N: go to ISSUE.
- either dim 0 or >MAX_N: pulse cfg_err, stay IDLE.
REQ-006 ISSUE: tile_start=1 for exactly one cycle, then COMPUTE.
REQ-007 COMPUTE: wait for tile_done, then DRAIN; tile_done in other states ignored.
REQ-008 DRAIN: oc_done=1; on sta_idle=1 go to FLUSH (same edge the coordinator raises its valid).
REQ-009 FLUSH: oc_done=0; pos_row/pos_col/pe_mask held; on oc_idle=1 go to NEXT.
REQ-010 NEXT: advance tile, row-major.
- pos_col+COLS < mat_cols: pos_col += COLS, go to ISSUE.
- else if pos_row+ROWS < mat_rows: pos_col=0, pos_row += ROWS, go to ISSUE.
- else: go to FIN.
- All sums computed in N_BITS+1 bits, no wrap.
REQ-011 FIN: layer_done=1 for one cycle, then IDLE; pos holds last tile.
REQ-012 pe_mask[i*COLS+j] = (pos_row+i < mat_rows) && (pos_col+j < mat_cols), compared in N_BITS+1 bits; all 0 in IDLE.
REQ-013 stall=1: state, pos, latched dims frozen; tile_start, layer_done, cfg_err forced 0 and re-emitted once after stall drops; oc_done, pe_mask, busy hold.
REQ-014 start while busy: ignored.
REQ-015 Latency: start -> tile_start 2 cycles; last oc_idle in FLUSH -> layer_done 2 cycles.

Reset
REQ-016 reset=0 at any clock edge, including mid-layer, forces IDLE next cycle.
- All outputs 0: busy, tile_start, pos_row, pos_col, pe_mask, oc_done, layer_done, cfg_err.
- Latched dims cleared.
- No partial pulse after release.

Structure
REQ-017 State enum typedef sched_state_t belongs in the shared sys_types package, as does any tile-geometry constant.
REQ-018 Mask generation is one sub-module, tile_mask_gen: combinational; inputs pos and dims, output pe_mask.

Verification
REQ-019 ROWS=COLS=4, MAX_N=64. Directed scenarios:
- 8x8 -> four tile_start at (0,0),(0,4),(4,0),(4,4); every pe_mask all-ones; one layer_done after fourth FLUSH.
- 6x5 -> tiles (0,0),(0,4),(4,0),(4,4); mask at (0,4) = bits {0,4,8,12}; at (4,0) = bits 0..7; at (4,4) = bits {0,4}.
- stall=1 for 3 cycles in DRAIN with sta_idle=1 -> oc_done held, no FLUSH entry until stall drops; stall on ISSUE cycle delays tile_start by exactly 3 cycles, single pulse.
- start with mat_rows=0, then 65 -> cfg_err pulse each time, busy stays 0, no tile_start; start pulsed in COMPUTE -> ignored.
- reset=0 for one cycle in COMPUTE of 8x8 -> next cycle IDLE, all outputs 0; fresh start replays from (0,0).
- 64x64 -> 256 tile_start pulses, last at (60,60), pos never wraps, layer_done once.

Source files
------------

// File: rtl/sys_types.sv
// Shared types and default tile geometry for the tile scheduler.
package sys_types;

  localparam int unsigned TileRows = 4;
  localparam int unsigned TileCols = 4;
  localparam int unsigned MaxDim   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCompute,
    StDrain,
    StFlush,
    StNext,
    StFin
  } sched_state_t;

endpackage

// File: rtl/tile_mask_gen.sv
// Per-PE active mask for a tile at (pos_row, pos_col) clipped against the matrix edge.
module tile_mask_gen
  import sys_types::*;
#(
  parameter int unsigned ROWS   = TileRows,
  parameter int unsigned COLS   = TileCols,
  parameter int unsigned N_BITS = $clog2(MaxDim)
) (
  input  logic [N_BITS-1:0]    pos_row_i,
  input  logic [N_BITS-1:0]    pos_col_i,
  input  logic [N_BITS:0]      mat_rows_i,
  input  logic [N_BITS:0]      mat_cols_i,
  output logic [ROWS*COLS-1:0] pe_mask_o
);

  logic [ROWS-1:0] row_ok;
  logic [COLS-1:0] col_ok;

  // Sums carry one extra bit so a tile near MAX_N never wraps back into range.
  always_comb begin
    row_ok    = '0;
    col_ok    = '0;
    pe_mask_o = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      row_ok[i] = ({1'b0, pos_row_i} + (N_BITS+1)'(i)) < mat_rows_i;
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      col_ok[j] = ({1'b0, pos_col_i} + (N_BITS+1)'(j)) < mat_cols_i;
    end
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        pe_mask_o[i*COLS+j] = row_ok[i] & col_ok[j];
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks a layer's output matrix tile by tile (row-major), handshaking with the
// systolic array and the output coordinator for each tile.
module tile_scheduler
  import sys_types::*;
#(
  parameter int unsigned ROWS   = TileRows,
  parameter int unsigned COLS   = TileCols,
  parameter int unsigned MAX_N  = MaxDim,
  parameter int unsigned N_BITS = $clog2(MAX_N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 start,
  input  logic [N_BITS:0]      mat_rows,
  input  logic [N_BITS:0]      mat_cols,
  input  logic                 tile_done,
  input  logic                 sta_idle,
  input  logic                 oc_idle,
  output logic                 busy,
  output logic                 tile_start,
  output logic [N_BITS-1:0]    pos_row,
  output logic [N_BITS-1:0]    pos_col,
  output logic [ROWS*COLS-1:0] pe_mask,
  output logic                 oc_done,
  output logic                 layer_done,
  output logic                 cfg_err
);

  localparam logic [N_BITS:0] RowStep = (N_BITS+1)'(ROWS);
  localparam logic [N_BITS:0] ColStep = (N_BITS+1)'(COLS);
  localparam logic [N_BITS:0] DimMax  = (N_BITS+1)'(MAX_N);

  sched_state_t         state_q, state_d;
  logic [N_BITS-1:0]    pos_row_q, pos_row_d, pos_col_q, pos_col_d;
  logic [N_BITS:0]      dim_rows_q, dim_rows_d, dim_cols_q, dim_cols_d;
  logic                 tile_start_q, tile_start_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [N_BITS:0]      next_row, next_col;
  logic                 dims_legal;
  logic [ROWS*COLS-1:0] mask_raw;

  always_comb begin
    next_row   = {1'b0, pos_row_q} + RowStep;
    next_col   = {1'b0, pos_col_q} + ColStep;
    dims_legal = (mat_rows != '0) && (mat_rows <= DimMax) &&
                 (mat_cols != '0) && (mat_cols <= DimMax);
  end

  // Pulses are registered; under stall a pending pulse is held so it is emitted once afterwards.
  always_comb begin
    state_d      = state_q;
    pos_row_d    = pos_row_q;
    pos_col_d    = pos_col_q;
    dim_rows_d   = dim_rows_q;
    dim_cols_d   = dim_cols_q;
    tile_start_d = stall ? tile_start_q : (state_q == StIssue);
    cfg_err_d    = stall ? cfg_err_q : 1'b0;
    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dim_rows_d = mat_rows;
            dim_cols_d = mat_cols;
            pos_row_d  = '0;
            pos_col_d  = '0;
            if (dims_legal) begin
              state_d = StIssue;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        StIssue:   state_d = StCompute;
        StCompute: if (tile_done) state_d = StDrain;
        StDrain:   if (sta_idle) state_d = StFlush;
        StFlush:   if (oc_idle) state_d = StNext;
        StNext: begin
          if (next_col < dim_cols_q) begin
            pos_col_d = next_col[N_BITS-1:0];
            state_d   = StIssue;
          end else if (next_row < dim_rows_q) begin
            pos_col_d = '0;
            pos_row_d = next_row[N_BITS-1:0];
            state_d   = StIssue;
          end else begin
            state_d = StFin;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pos_row_q    <= '0;
      pos_col_q    <= '0;
      dim_rows_q   <= '0;
      dim_cols_q   <= '0;
      tile_start_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_row_q    <= pos_row_d;
      pos_col_q    <= pos_col_d;
      dim_rows_q   <= dim_rows_d;
      dim_cols_q   <= dim_cols_d;
      tile_start_q <= tile_start_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  tile_mask_gen #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .N_BITS (N_BITS)
  ) u_mask_gen (
    .pos_row_i  (pos_row_q),
    .pos_col_i  (pos_col_q),
    .mat_rows_i (dim_rows_q),
    .mat_cols_i (dim_cols_q),
    .pe_mask_o  (mask_raw)
  );

  always_comb begin
    busy       = (state_q != StIdle);
    oc_done    = (state_q == StDrain);
    layer_done = (state_q == StFin) && !stall;
    tile_start = tile_start_q && !stall;
    cfg_err    = cfg_err_q && !stall;
    pos_row    = pos_row_q;
    pos_col    = pos_col_q;
    pe_mask    = busy ? mask_raw : '0;
  end

endmodule
